// File: rtl/serial_pkg.sv
// Shared types and constants for the operand serializer: FSM state encoding,
// default operand width and the sizing helper for the shared cycle counter.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bits needed to hold 0..max(w,f); never less than one bit.
  function automatic int cnt_bits(input int w, input int f);
    int m;
    m = (w > f) ? w : f;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/piso_reg.sv
// Parallel-in serial-out register: load has priority over shift, shifts right
// so bit 0 is presented first on q.
module piso_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q
);

  logic [WIDTH-1:0] data;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= d;
    end else if (shift) begin
      data <= data >> 1;
    end
  end

  assign q = data[0];

endmodule

// File: rtl/operand_serializer.sv
// Serializes an operand pair LSB-first for a bit-serial adder, then idles for
// FLUSH_CYCLES. Define OPERAND_SKID_EN to add a one-entry operand buffer.
module operand_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             done
);

  localparam int             CW         = cnt_bits(WIDTH, FLUSH_CYCLES);
  localparam logic [CW-1:0]  SHIFT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  FLUSH_LAST = CW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic             accept, start_frame, frame_end, cnt_clr, in_shift;
  logic             a_bit, b_bit;
  logic [WIDTH-1:0] load_a, load_b;

  assign accept   = in_valid && in_ready;
  assign in_shift = (state == SHIFT);

  // Last cycle of the frame: end of flush, or end of shift when there is no flush.
  assign frame_end = (state == FLUSH && cnt == FLUSH_LAST) ||
                     (in_shift && cnt == SHIFT_LAST && FLUSH_CYCLES == 0);

`ifdef OPERAND_SKID_EN
  logic             skid_full, take_buf;
  logic [WIDTH-1:0] skid_a, skid_b;

  assign in_ready    = !rst && !skid_full;
  assign take_buf    = skid_full && ((state == IDLE) || frame_end);
  assign start_frame = take_buf || (state == IDLE && accept);
  assign load_a      = take_buf ? skid_a : op_a;
  assign load_b      = take_buf ? skid_b : op_b;

  // A store in the same cycle as a transfer wins, so the buffer refills.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_full <= 1'b0;
      skid_a    <= '0;
      skid_b    <= '0;
    end else if (accept && state != IDLE) begin
      skid_full <= 1'b1;
      skid_a    <= op_a;
      skid_b    <= op_b;
    end else if (take_buf) begin
      skid_full <= 1'b0;
    end
  end
`else
  assign in_ready    = !rst && (state == IDLE);
  assign start_frame = (state == IDLE) && accept;
  assign load_a      = op_a;
  assign load_b      = op_b;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_clr ? '0 : cnt + 1'b1;
    end
  end

  // NOTE: next_state gets its default before the case so no path infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  ;
      SHIFT: if (cnt == SHIFT_LAST) next_state = (FLUSH_CYCLES == 0) ? IDLE : FLUSH;
      FLUSH: if (cnt == FLUSH_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (start_frame) next_state = SHIFT;
    cnt_clr = (next_state != state) || start_frame || (state == IDLE);
  end

  piso_reg #(.WIDTH(WIDTH)) u_piso_a (
    .clk(clk), .rst(rst), .load(start_frame), .shift(in_shift), .d(load_a), .q(a_bit)
  );

  piso_reg #(.WIDTH(WIDTH)) u_piso_b (
    .clk(clk), .rst(rst), .load(start_frame), .shift(in_shift), .d(load_b), .q(b_bit)
  );

  assign ser_a     = in_shift && a_bit;
  assign ser_b     = in_shift && b_bit;
  assign ser_valid = in_shift;
  assign ser_first = in_shift && (cnt == '0);
  assign ser_last  = in_shift && (cnt == SHIFT_LAST);
  assign done      = frame_end;

endmodule

// File: doc/operand_serializer.md
OPERAND_SERIALIZER -- requirements
Module: operand_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits.
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 4, giving the number of idle-bit cycles after each operand frame; the legal range is 0..15.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: the operand pair on op_a/op_b is offered.
REQ-006 Port in_ready, output, 1 bit: the block can accept an operand pair this cycle.
REQ-007 Port op_a, input, WIDTH bits: parallel operand A.
REQ-008 Port op_b, input, WIDTH bits: parallel operand B.
REQ-009 Port ser_a, output, 1 bit: serial A bit, LSB first, feeding the serial adder a input.
REQ-010 Port ser_b, output, 1 bit: serial B bit, LSB first, feeding the serial adder b input.
REQ-011 Port ser_valid, output, 1 bit: ser_a/ser_b carry operand data this cycle.
REQ-012 Port ser_first, output, 1 bit: the current bit is bit 0; downstream uses it to clear the carry flop.
REQ-013 Port ser_last, output, 1 bit: the current bit is bit WIDTH-1.
REQ-014 Port done, output, 1 bit: one-cycle pulse when the frame and its flush are complete.

Function
REQ-015 An operand pair SHALL be accepted on a rising edge where in_valid && in_ready; the accepted operands are latched into two internal shift registers.
REQ-016 The FSM SHALL have states IDLE, SHIFT and FLUSH.
REQ-017 IDLE SHALL go to SHIFT on accept; SHIFT SHALL go to FLUSH after WIDTH cycles, or to IDLE when FLUSH_CYCLES=0; FLUSH SHALL go to IDLE after FLUSH_CYCLES cycles.
REQ-018 In SHIFT, ser_a/ser_b SHALL equal the current LSB of the A/B shift registers, ser_valid SHALL be 1, and both registers SHALL shift right by one each cycle.
REQ-019 The first SHIFT cycle SHALL be the cycle after the accept edge (latency 1); bit k appears in SHIFT cycle k.
REQ-020 ser_first SHALL be 1 only in SHIFT cycle 0, and ser_last SHALL be 1 only in SHIFT cycle WIDTH-1; when WIDTH=1, both are 1 in the same cycle.
REQ-021 In IDLE and FLUSH, ser_a, ser_b, ser_valid, ser_first and ser_last SHALL all be 0.
REQ-022 done SHALL pulse for exactly one cycle: the final FLUSH cycle, or the final SHIFT cycle when FLUSH_CYCLES=0.
REQ-023 A single internal counter SHALL count SHIFT and FLUSH cycles; it is sized ceil(log2(max(WIDTH,FLUSH_CYCLES)+1)) bits and cleared on every state entry.
REQ-024 Without skid (see Configuration), in_ready SHALL equal (state==IDLE), and in_valid outside IDLE SHALL be ignored.
REQ-025 op_a/op_b changes after the accept edge SHALL NOT affect the frame in progress.

Reset
REQ-026 Asserting rst at any time SHALL force the FSM to IDLE, the counter to 0, both shift registers to 0 and the skid buffer to empty; any frame in progress is abandoned and is not completed later.
REQ-027 While rst is asserted, outputs SHALL be: ser_a, ser_b, ser_valid, ser_first, ser_last, done = 0; in_ready = 0.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-029 Macro OPERAND_SKID_EN, when defined, SHALL add a one-entry operand buffer; in that case in_ready = !skid_full, and pairs accepted in SHIFT or FLUSH are stored in the buffer.
REQ-030 With OPERAND_SKID_EN defined, on the done cycle a full buffer SHALL be transferred to the shift registers and the FSM SHALL enter SHIFT directly (back-to-back frames, no IDLE cycle).
REQ-031 With OPERAND_SKID_EN defined, an accept in the same cycle as the done-transfer SHALL refill the buffer.
REQ-032 Without OPERAND_SKID_EN, no buffer logic SHALL exist and REQ-024 applies.

Structure
REQ-033 Package serial_pkg SHALL hold the FSM state enum (IDLE, SHIFT, FLUSH) and the default WIDTH constant.
REQ-034 Sub-module piso_reg (parallel-in serial-out, load/shift enable, async reset) SHALL be instantiated twice, once for A and once for B.

Verification
REQ-035 Scenario: WIDTH=4, accept A=4'b1011, B=4'b0110 -> ser_a=1,1,0,1 and ser_b=0,1,1,0 over cycles 1..4; ser_first in cycle 1, ser_last in cycle 4; done in cycle 8.
REQ-036 Scenario: FLUSH_CYCLES=0, A=4'hF, B=4'h1 -> done coincides with ser_last in cycle 4; in_ready is 1 in cycle 5.
REQ-037 Scenario: rst pulsed during SHIFT cycle 2 -> all outputs 0 immediately; no done pulse; the next accepted frame starts with ser_first.
REQ-038 Scenario: without OPERAND_SKID_EN, in_valid held high continuously -> accepts spaced 9 cycles apart (WIDTH+FLUSH_CYCLES+1).
REQ-039 Scenario: with OPERAND_SKID_EN, a second pair offered in SHIFT cycle 1 -> second frame's ser_first is the cycle after the first frame's done; in_ready is 0 while the buffer is full.
REQ-040 Scenario: WIDTH=1, A=1, B=1 -> ser_first and ser_last both 1 in cycle 1.
